// File: rtl/fetch_stage_pkg.sv
// Shared processor types: fetch FSM states, the NOP bubble word, and the
// instruction/PC types used by the fetch stage and the execute control.
package fetch_stage_pkg;

   typedef logic [31:0] instr_t;
   typedef logic [31:0] pc_t;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_t;

   localparam instr_t NOP_WORD_C = 32'd0;

   // Word-addressed increment; wraps modulo 2^32.
   function automatic pc_t pc_inc(input pc_t p);
      return p + 32'd1;
   endfunction

endpackage

// File: rtl/fetch_stage_fd_register.sv
// F/D pipeline latch: flush beats load, load beats hold; async active-high reset.
// Reset and flush both leave a NOP bubble with valid low.
module fd_register
   import fetch_stage_pkg::*;
#(
   parameter instr_t NOP_WORD = NOP_WORD_C
) (
   input  logic   i_clk,
   input  logic   i_rst,
   input  logic   i_load,
   input  logic   i_flush,
   input  instr_t i_instr,
   input  pc_t    i_pc,
   output instr_t o_instr,
   output pc_t    o_pc,
   output logic   o_valid
);

   instr_t r_instr;
   pc_t    r_pc;
   logic   r_valid;

   // A flush keeps the last fd_pc; only the instruction and valid flag are bubbled.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_instr <= NOP_WORD;
         r_pc    <= 32'd0;
         r_valid <= 1'b0;
      end else if (i_flush) begin
         r_instr <= NOP_WORD;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_instr <= i_instr;
         r_pc    <= i_pc;
         r_valid <= 1'b1;
      end
   end

   assign o_instr = r_instr;
   assign o_pc    = r_pc;
   assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, BOOT/RUN/HALTED FSM and F/D register.
// In RUN the priority is halt, then redirect, then stall, then normal fetch.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter pc_t    RESET_PC = 32'd0,
   parameter int     ADDR_W   = 12,
   parameter instr_t NOP_WORD = NOP_WORD_C
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              stall,
   input  logic              redirect_valid,
   input  pc_t               redirect_target,
   input  logic              halt,
   output logic [ADDR_W-1:0] imem_addr,
   input  instr_t            imem_data,
   output instr_t            fd_instruction,
   output pc_t               fd_pc,
   output logic              fd_valid,
   output pc_t               pc,
   output logic [31:0]       fetch_count
);

   fetch_state_t r_state;
   pc_t          r_pc;
   logic [31:0]  r_fetch_count;

   logic w_run;
   logic w_halt_now;
   logic w_redirect;
   logic w_advance;
   logic w_flush;
   pc_t  w_pc_inc;

   assign w_run      = (r_state == ST_RUN);
   assign w_halt_now = w_run && halt;
   assign w_redirect = w_run && !halt && redirect_valid;
   assign w_advance  = w_run && !halt && !redirect_valid && !stall;
   // HALTED keeps flushing so the F/D register can never hold a live word there.
   assign w_flush    = w_halt_now || w_redirect || (r_state == ST_HALTED);
   assign w_pc_inc   = pc_inc(r_pc);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= ST_BOOT;
         r_pc          <= RESET_PC;
         r_fetch_count <= 32'd0;
      end else begin
         case (r_state)
            ST_BOOT: begin
               r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (halt) begin
                  r_state <= ST_HALTED;
               end else if (redirect_valid) begin
                  r_pc <= redirect_target;
               end else if (!stall) begin
                  r_pc          <= w_pc_inc;
                  r_fetch_count <= r_fetch_count + 32'd1;
               end
            end
            ST_HALTED: begin
               r_state <= ST_HALTED;
            end
            default: begin
               r_state <= ST_BOOT;
            end
         endcase
      end
   end

   fd_register #(
      .NOP_WORD (NOP_WORD)
   ) u_fd_register (
      .i_clk   (clock),
      .i_rst   (reset),
      .i_load  (w_advance),
      .i_flush (w_flush),
      .i_instr (imem_data),
      .i_pc    (w_pc_inc),
      .o_instr (fd_instruction),
      .o_pc    (fd_pc),
      .o_valid (fd_valid)
   );

   assign imem_addr   = r_pc[ADDR_W-1:0];
   assign pc          = r_pc;
   assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage; imem returns 32'h1000_0000 + address.
module tb_fetch_stage;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = 32'd0;
   logic        halt = 1'b0;
   logic [11:0] imem_addr;
   logic [31:0] imem_data;
   logic [31:0] fd_instruction;
   logic [31:0] fd_pc;
   logic        fd_valid;
   logic [31:0] pc;
   logic [31:0] fetch_count;

   int n_vec  = 0;
   int n_chk  = 0;
   int n_miss = 0;

   always #5 clock = ~clock;

   assign imem_data = 32'h1000_0000 + {20'd0, imem_addr};

   fetch_stage #(
      .RESET_PC (32'd0),
      .ADDR_W   (12),
      .NOP_WORD (32'd0)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .halt            (halt),
      .imem_addr       (imem_addr),
      .imem_data       (imem_data),
      .fd_instruction  (fd_instruction),
      .fd_pc           (fd_pc),
      .fd_valid        (fd_valid),
      .pc              (pc),
      .fetch_count     (fetch_count)
   );

   typedef struct {
      logic        stall;
      logic        rv;
      logic [31:0] tgt;
      logic        halt;
      logic [31:0] e_pc;
      logic [31:0] e_ins;
      logic [31:0] e_fpc;
      logic        e_v;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t tbl[18];

   function automatic vec_t mk(input logic s, input logic rv, input logic [31:0] tgt,
                               input logic h, input logic [31:0] e_pc,
                               input logic [31:0] e_ins, input logic [31:0] e_fpc,
                               input logic e_v, input logic [31:0] e_cnt);
      vec_t v;
      v.stall = s;   v.rv = rv;       v.tgt = tgt;     v.halt = h;
      v.e_pc  = e_pc; v.e_ins = e_ins; v.e_fpc = e_fpc; v.e_v = e_v; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ins,
                          input logic [31:0] e_fpc, input logic e_v, input logic [31:0] e_cnt);
      logic [31:0] e_addr;
      e_addr = {20'd0, e_pc[11:0]};
      chk({tag, ".pc"},        pc,                  e_pc);
      chk({tag, ".imem_addr"}, {20'd0, imem_addr},  e_addr);
      chk({tag, ".fd_instr"},  fd_instruction,      e_ins);
      chk({tag, ".fd_pc"},     fd_pc,               e_fpc);
      chk({tag, ".fd_valid"},  {31'd0, fd_valid},   {31'd0, e_v});
      chk({tag, ".count"},     fetch_count,         e_cnt);
   endtask

   task automatic step(input logic s, input logic rv, input logic [31:0] tgt, input logic h);
      stall = s; redirect_valid = rv; redirect_target = tgt; halt = h;
      @(posedge clock);
      #1;
      n_vec++;
   endtask

   initial begin
      // Boot, straight-line fetch, 3-cycle stall at pc=5, redirect under stall, halt at pc=9.
      tbl[0]  = mk(0, 0, 32'h0,  0, 32'd0,  32'h0,         32'd0,  0, 32'd0);
      tbl[1]  = mk(0, 0, 32'h0,  0, 32'd1,  32'h1000_0000, 32'd1,  1, 32'd1);
      tbl[2]  = mk(0, 0, 32'h0,  0, 32'd2,  32'h1000_0001, 32'd2,  1, 32'd2);
      tbl[3]  = mk(0, 0, 32'h0,  0, 32'd3,  32'h1000_0002, 32'd3,  1, 32'd3);
      tbl[4]  = mk(0, 0, 32'h0,  0, 32'd4,  32'h1000_0003, 32'd4,  1, 32'd4);
      tbl[5]  = mk(0, 0, 32'h0,  0, 32'd5,  32'h1000_0004, 32'd5,  1, 32'd5);
      tbl[6]  = mk(1, 0, 32'h0,  0, 32'd5,  32'h1000_0004, 32'd5,  1, 32'd5);
      tbl[7]  = mk(1, 0, 32'h0,  0, 32'd5,  32'h1000_0004, 32'd5,  1, 32'd5);
      tbl[8]  = mk(1, 0, 32'h0,  0, 32'd5,  32'h1000_0004, 32'd5,  1, 32'd5);
      tbl[9]  = mk(0, 0, 32'h0,  0, 32'd6,  32'h1000_0005, 32'd6,  1, 32'd6);
      tbl[10] = mk(1, 1, 32'h40, 0, 32'h40, 32'h0,         32'd6,  0, 32'd6);
      tbl[11] = mk(0, 0, 32'h0,  0, 32'h41, 32'h1000_0040, 32'h41, 1, 32'd7);
      tbl[12] = mk(0, 1, 32'h9,  0, 32'd9,  32'h0,         32'h41, 0, 32'd7);
      tbl[13] = mk(1, 1, 32'h77, 1, 32'd9,  32'h0,         32'h41, 0, 32'd7);
      tbl[14] = mk(0, 1, 32'h80, 0, 32'd9,  32'h0,         32'h41, 0, 32'd7);
      tbl[15] = mk(1, 0, 32'h0,  0, 32'd9,  32'h0,         32'h41, 0, 32'd7);
      tbl[16] = mk(0, 0, 32'h0,  0, 32'd9,  32'h0,         32'h41, 0, 32'd7);
      tbl[17] = mk(0, 0, 32'h0,  1, 32'd9,  32'h0,         32'h41, 0, 32'd7);

      #2;
      chk_all("reset", 32'd0, 32'h0, 32'd0, 0, 32'd0);
      #4 reset = 1'b0;

      for (int i = 0; i < 18; i++) begin
         step(tbl[i].stall, tbl[i].rv, tbl[i].tgt, tbl[i].halt);
         chk_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_ins, tbl[i].e_fpc,
                 tbl[i].e_v, tbl[i].e_cnt);
      end

      // Leave HALTED via reset, then get to RUN with a live F/D word at pc=20.
      #2 reset = 1'b1;
      #2 reset = 1'b0;
      step(0, 0, 32'h0, 0);
      step(0, 1, 32'd19, 0);
      step(0, 0, 32'h0, 0);
      chk_all("pre_rst", 32'd20, 32'h1000_0013, 32'd20, 1, 32'd1);

      // Async reset mid-cycle: outputs clear without a clock edge.
      #3 reset = 1'b1;
      #1;
      chk_all("async_rst", 32'd0, 32'h0, 32'd0, 0, 32'd0);
      #2 reset = 1'b0;

      // BOOT ignores redirect and halt; capture lands on the second edge.
      step(0, 1, 32'h55, 1);
      chk_all("boot_ignore", 32'd0, 32'h0, 32'd0, 0, 32'd0);
      step(0, 0, 32'h0, 0);
      chk_all("boot_first", 32'd1, 32'h1000_0000, 32'd1, 1, 32'd1);

      // PC wrap at 32'hFFFF_FFFF: imem_addr aliases, fd_pc wraps to 0.
      step(0, 1, 32'hFFFF_FFFF, 0);
      chk_all("wrap_redir", 32'hFFFF_FFFF, 32'h0, 32'd1, 0, 32'd1);
      step(0, 0, 32'h0, 0);
      chk_all("wrap_edge", 32'd0, 32'h1000_0FFF, 32'd0, 1, 32'd2);
      step(0, 0, 32'h0, 0);
      chk_all("wrap_next", 32'd1, 32'h1000_0000, 32'd1, 1, 32'd3);

      // Halt beats a simultaneous redirect and stall.
      step(1, 1, 32'h33, 1);
      chk_all("halt_prio", 32'd1, 32'h0, 32'd1, 0, 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
